// File: rtl/hd_mem_pkg.sv
// rtl/hd_mem_pkg.sv - shared types and default widths for the HD memory pair reader
package hd_mem_pkg;

    localparam int HD_DATA_WIDTH = 16;
    localparam int HD_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [HD_DATA_WIDTH-1:0] data_0;
        logic [HD_DATA_WIDTH-1:0] data_1;
        logic                     last;
    } pair_t;

endpackage

// File: rtl/hv_pair_fifo.sv
// rtl/hv_pair_fifo.sv - two-entry FIFO of returned word pairs
module hv_pair_fifo
    import hd_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pair_t      push_data,
    input  logic       pop,
    output pair_t      head,
    output logic [1:0] occ,
    output logic       full,
    output logic       empty
);

    pair_t      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;
    logic       w_do_push;
    logic       w_do_pop;

    assign full      = (r_occ == 2'd2);
    assign empty     = (r_occ == 2'd0);
    assign occ       = r_occ;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/hv_mem_pair_reader.sv
// rtl/hv_mem_pair_reader.sv - issues paired dual-port RAM reads and streams the returned pairs
module hv_mem_pair_reader
    import hd_mem_pkg::*;
#(
    parameter int DATA_WIDTH = HD_DATA_WIDTH,
    parameter int ADDR_WIDTH = HD_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_pairs,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address_0,
    output logic [ADDR_WIDTH-1:0] mem_address_1,
    output logic                  mem_cs_0,
    output logic                  mem_cs_1,
    output logic                  mem_oe_0,
    output logic                  mem_oe_1,
    output logic                  mem_we_0,
    output logic                  mem_we_1,
    input  logic [DATA_WIDTH-1:0] mem_data_0_out,
    input  logic [DATA_WIDTH-1:0] mem_data_1_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_0,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic                  out_last
);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;
    logic                  w_done_next;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pop;
    logic [2:0]            w_credit_used;
    logic [2:0]            w_credit_free;
    logic [1:0]            w_occ;
    logic                  w_full;
    logic                  w_empty;
    pair_t                 w_head;
    pair_t                 w_push_data;

    // A slot is reserved for the read in flight, so the buffer can never overflow.
    assign w_pop         = out_valid & out_ready;
    assign w_credit_used = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_credit_free = 3'd2 + {2'b00, w_pop};
    assign w_issue       = (r_state == ST_RUN) && (w_credit_used < w_credit_free);
    assign w_last_issue  = w_issue && (r_remaining == ADDR_WIDTH'(1));

    always_comb begin
        w_next_state = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_pairs != '0) w_next_state = ST_RUN;
                    else                 w_done_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last_issue) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && out_last) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_done          <= w_done_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if ((r_state == ST_IDLE) && start && (num_pairs != '0)) begin
                r_addr      <= base_addr;
                r_remaining <= num_pairs;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(2);
                r_remaining <= r_remaining - ADDR_WIDTH'(1);
            end
        end
    end

    assign w_push_data.data_0 = mem_data_0_out;
    assign w_push_data.data_1 = mem_data_1_out;
    assign w_push_data.last   = r_inflight_last;

    hv_pair_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .occ       (w_occ),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Addresses are driven only on issue cycles so the bus idles at zero.
    assign mem_address_0 = w_issue ? r_addr : '0;
    assign mem_address_1 = w_issue ? (r_addr + ADDR_WIDTH'(1)) : '0;
    assign mem_cs_0      = w_issue;
    assign mem_cs_1      = w_issue;
    assign mem_oe_0      = w_issue;
    assign mem_oe_1      = w_issue;
    assign mem_we_0      = 1'b0;
    assign mem_we_1      = 1'b0;

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign out_valid  = ~w_empty;
    assign out_data_0 = w_head.data_0;
    assign out_data_1 = w_head.data_1;
    assign out_last   = w_head.last & ~w_empty;

endmodule

// File: tb/tb_hv_mem_pair_reader.sv
// tb/tb_hv_mem_pair_reader.sv - scoreboard bench for the HD memory pair reader
module tb_hv_mem_pair_reader;

    localparam int DW = 16;
    localparam int AW = 8;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_pairs = '0;
    logic          busy, done;
    logic [AW-1:0] mem_address_0, mem_address_1;
    logic          mem_cs_0, mem_cs_1, mem_oe_0, mem_oe_1, mem_we_0, mem_we_1;
    logic [DW-1:0] mem_data_0_out = '0;
    logic [DW-1:0] mem_data_1_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data_0, out_data_1;
    logic          out_last;

    logic [DW-1:0] ram [256];
    exp_t          exp_q [$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int done_due = -1;
    int done_cyc = 0;
    int first_valid_cyc = -1;
    int start_cyc = 0;
    int issued = 0;
    int popped = 0;
    int pops_cmd = 0;
    int ready_mode = 0;
    int phase = 0;
    bit done_seen = 0;
    bit zero_win = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d0, prev_d1;
    logic          prev_last;

    hv_mem_pair_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_pairs      (num_pairs),
        .busy           (busy),
        .done           (done),
        .mem_address_0  (mem_address_0),
        .mem_address_1  (mem_address_1),
        .mem_cs_0       (mem_cs_0),
        .mem_cs_1       (mem_cs_1),
        .mem_oe_0       (mem_oe_0),
        .mem_oe_1       (mem_oe_1),
        .mem_we_0       (mem_we_0),
        .mem_we_1       (mem_we_1),
        .mem_data_0_out (mem_data_0_out),
        .mem_data_1_out (mem_data_1_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data_0     (out_data_0),
        .out_data_1     (out_data_1),
        .out_last       (out_last)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Synchronous dual-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_cs_0 && mem_oe_0) mem_data_0_out <= ram[mem_address_0];
        if (mem_cs_1 && mem_oe_1) mem_data_1_out <= ram[mem_address_1];
    end

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        cmp_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        phase++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (phase % 3 == 0);
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and polices the stream rules
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall)
                chk("stable_hold",
                    out_valid && out_data_0 == prev_d0 && out_data_1 == prev_d1 && out_last == prev_last,
                    {out_valid, out_data_0, out_data_1, out_last}, {1'b1, prev_d0, prev_d1, prev_last});
            if (mem_cs_0 || mem_cs_1) begin
                issued++;
                chk("port_ctrl",
                    mem_cs_0 && mem_cs_1 && mem_oe_0 && mem_oe_1 && !mem_we_0 && !mem_we_1,
                    {mem_cs_0, mem_cs_1, mem_oe_0, mem_oe_1, mem_we_0, mem_we_1}, 6'b111100);
            end
            if (zero_win)
                chk("zero_len_no_cs", !(mem_cs_0 || mem_cs_1), {mem_cs_0, mem_cs_1}, 0);
            if (out_valid && out_ready) begin
                popped++;
                pops_cmd++;
                if (exp_q.size() == 0) begin
                    chk("extra_pair", 1'b0, {out_data_0, out_data_1}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pair_data",
                        out_data_0 == e.d0 && out_data_1 == e.d1 && out_last == e.last,
                        {out_data_0, out_data_1, out_last}, {e.d0, e.d1, e.last});
                    if (e.last) done_due = cyc + 1;
                end
            end
            if ((mem_cs_0 || mem_cs_1) || (out_valid && out_ready))
                chk("outstanding_le2", (issued - popped) <= 2, issued - popped, 2);
            if (done || cyc == done_due) begin
                chk("done_timing", done && cyc == done_due, {done, 32'(cyc)}, {1'b1, 32'(done_due)});
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
                done_due = -1;
            end
            prev_stall = out_valid && !out_ready;
            prev_d0    = out_data_0;
            prev_d1    = out_data_1;
            prev_last  = out_last;
        end
    end

    task automatic push_expected(input logic [AW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] b;
            a = base + AW'(2 * k);
            b = a + AW'(1);
            exp_q.push_back('{ram[a], ram[b], (k == n - 1)});
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name,
            {busy, done, out_valid, out_last, out_data_0, out_data_1, mem_cs_0, mem_cs_1,
             mem_oe_0, mem_oe_1, mem_we_0, mem_we_1, mem_address_0, mem_address_1} == '0,
            {busy, done, out_valid, out_last, out_data_0, out_data_1, mem_cs_0, mem_cs_1,
             mem_oe_0, mem_oe_1, mem_we_0, mem_we_1, mem_address_0, mem_address_1}, 0);
    endtask

    task automatic run_cmd(input logic [AW-1:0] base, input int n, input int mode, input bit extra_start);
        ready_mode = mode;
        push_expected(base, n);
        first_valid_cyc = -1;
        done_seen = 0;
        pops_cmd  = 0;
        start_cyc = cyc;
        zero_win  = (n == 0);
        if (n == 0) done_due = cyc + 1;
        start = 1'b1;
        base_addr = base;
        num_pairs = AW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        num_pairs = AW'($urandom);
        for (int i = 0; i < 400 && !done_seen; i++) begin
            if (extra_start && i == 2) begin
                start = 1'b1;
                base_addr = 8'h40;
                num_pairs = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("cmd_done", done_seen, done_seen, 1);
        zero_win = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic read with timing checks
        run_cmd(8'h10, 4, 0, 0);
        chk("first_valid_latency", first_valid_cyc - start_cyc == 3, first_valid_cyc - start_cyc, 3);
        chk("done_latency", done_cyc - start_cyc == 7, done_cyc - start_cyc, 7);

        // Address wrap
        run_cmd(8'hFE, 2, 0, 0);

        // Backpressure 1,0,0 pattern
        phase = 2;
        run_cmd(8'h20, 5, 1, 0);

        // Zero length, then start while busy
        run_cmd(8'h33, 0, 0, 0);
        run_cmd(8'h60, 6, 0, 1);

        // Reset during pair 2 of 8
        ready_mode = 0;
        push_expected(8'h30, 8);
        done_seen = 0;
        pops_cmd  = 0;
        start = 1'b1;
        base_addr = 8'h30;
        num_pairs = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && pops_cmd < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_pair2", pops_cmd >= 2, pops_cmd, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_cmd");
        exp_q.delete();
        done_due = -1;
        issued = 0;
        popped = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no_done_after_reset", !done_seen && !busy, {done_seen, busy}, 0);
        run_cmd(8'h50, 1, 0, 0);

        // Randomized commands over random RAM contents with random backpressure
        for (int i = 0; i < 256; i++) ram[i] = DW'($urandom);
        for (int t = 0; t < 14; t++)
            run_cmd(AW'($urandom_range(0, 255)), $urandom_range(0, 12), 2, ($urandom_range(0, 3) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hv_mem_pair_reader.md
# hv_mem_pair_reader

Read-side initiator for the team's dual-port synchronous RAM. It turns one start command (base address, pair count) into back-to-back reads on both RAM ports: port 0 reads even offsets and port 1 reads odd offsets. Returned words are delivered as 2-word pairs on a valid/ready stream, which feeds the HD encode/compare datapath. The block absorbs the RAM's 1-cycle read latency and applies downstream backpressure without dropping data.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width; also the width of the pair count
- clk  in  1  sole clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- num_pairs  in  ADDR_WIDTH  pairs to read; 0 is legal
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  1-cycle pulse when the command is complete
- mem_address_0 / mem_address_1  out  ADDR_WIDTH  RAM port addresses
- mem_cs_0 / mem_cs_1  out  1  chip selects, high only on issue cycles
- mem_oe_0 / mem_oe_1  out  1  equal to the corresponding cs
- mem_we_0 / mem_we_1  out  1  constant 0
- mem_data_0_out / mem_data_1_out  in  DATA_WIDTH  RAM read data, valid the cycle after issue
- out_valid  out  1  a pair is available
- out_ready  in  1  consumer accepts the pair
- out_data_0 / out_data_1  out  DATA_WIDTH  even-offset word / odd-offset word
- out_last  out  1  qualifies the final pair of the command

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start with num_pairs != 0: latch base_addr, load remaining = num_pairs, go to RUN.
  - start with num_pairs == 0: pulse done on the next cycle, stay in IDLE, issue no reads.
- RUN:
  - Issue pair k with address_0 = base + 2k and address_1 = base + 2k + 1, both modulo 2^ADDR_WIDTH (wrap is silent).
  - Issue condition: occ + inflight − pop < 2, where occ is the 2-entry buffer occupancy, inflight is 1 if a pair was issued last cycle, and pop = out_valid & out_ready.
  - mem_cs/oe depend combinationally on state, occ, inflight and out_ready.
  - After the last issue, go to DRAIN.
- Capture: the cycle after an issue, write mem_data_0_out and mem_data_1_out into the buffer. A pair is never lost and never duplicated.
- DRAIN: when the pair tagged last is popped, pulse done in the next cycle and return to IDLE.
- out_last is stored per buffer entry and set only for pair num_pairs−1.
- start is ignored while busy.
- Stream rule: once out_valid is high, out_valid and the data stay stable until popped.

## Timing
- Reset values: busy 0, done 0, out_valid 0, out_last 0, out_data_* 0, mem_cs/oe/we 0, mem_address_* 0. State is IDLE, and the buffer and inflight are cleared.
- Start accepted at cycle 0:
  - busy = 1 and first issue at cycle 1.
  - RAM data at cycle 2, written to the buffer at the end of cycle 2.
  - First out_valid at cycle 3.
- With out_ready held high, throughput is 1 pair per cycle. The last pair for N pairs is valid at cycle N+2, and done pulses at cycle N+3.
- With out_ready low, at most 2 issues happen beyond the last pop; issue then stalls until a pop.
- Reset mid-command: immediate return to IDLE, with buffer contents and the inflight read discarded. No done pulse.

## Structure
- Package hd_mem_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN);
  - the pair struct typedef (data_0, data_1, last);
  - default DATA_WIDTH/ADDR_WIDTH localparams, shared with the RAM instantiation.
- Sub-module hv_pair_fifo: 2-entry FIFO of the pair struct with push, pop, occ[1:0] and full/empty. The top level holds the FSM, counters, address generation and credit logic.

## Test plan
- Basic read: RAM preloaded with mem[i] = i; base=0x10, num_pairs=4, out_ready=1 → pairs (0x10,0x11) through (0x16,0x17) on cycles 3–6; out_last only on (0x16,0x17); done at cycle 7.
- Wrap: base=0xFE, num_pairs=2 → pairs (0xFE,0xFF) then (0x00,0x01).
- Backpressure: num_pairs=5 with out_ready toggling 1,0,0,1,… → all 5 pairs in order, no duplicates, at most 2 pairs held while stalled, and out_data stable whenever out_valid=1 and out_ready=0.
- Zero length and start while busy: num_pairs=0 → done 1 cycle later with no mem_cs. A second start during RUN is ignored.
- Reset mid-command: rst_n low during pair 2 of 8 → all outputs at reset values and no done. A new command of 1 pair then completes normally.
